// File: rtl/full_adder.sv
// full_adder: 1-bit full adder with optional output register and stored carry for bit-serial addition
module full_adder #(
    parameter bit REGISTERED = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic e1,
    input  logic e2,
    input  logic cin,
    input  logic en,
    input  logic chain,
    output logic sum,
    output logic cout,
    output logic valid
);
    logic carry_q, ci, s, c;
    // select carry source and form the combinational sum/carry
    always_comb begin
        ci = chain ? carry_q : cin;
        s  = e1 ^ e2 ^ ci;
        c  = (e1 & e2) | (e1 & ci) | (e2 & ci);
    end
    // stored carry advances only on an enabled operation
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) carry_q <= 1'b0;
        else if (en) carry_q <= c;
    generate
        if (REGISTERED) begin : g_reg
            logic sum_q, cout_q, valid_q;
            // capture result on en, hold otherwise; valid marks a fresh capture
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) begin
                    sum_q   <= 1'b0;
                    cout_q  <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= en;
                    if (en) begin
                        sum_q  <= s;
                        cout_q <= c;
                    end
                end
            assign sum   = sum_q;
            assign cout  = cout_q;
            assign valid = valid_q;
        end else begin : g_comb
            assign sum   = s;
            assign cout  = c;
            assign valid = en;
        end
    endgenerate
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed checks of registered and combinational full_adder variants
module tb_full_adder;
    logic clk = 1'b0, rst_n = 1'b0, e1 = 1'b0, e2 = 1'b0, cin = 1'b0, en = 1'b0, chain = 1'b0;
    logic r_sum, r_cout, r_valid, c_sum, c_cout, c_valid;
    int n_cmp = 0, n_err = 0;

    full_adder #(.REGISTERED(1'b1)) u_reg (
        .clk(clk), .rst_n(rst_n), .e1(e1), .e2(e2), .cin(cin), .en(en), .chain(chain),
        .sum(r_sum), .cout(r_cout), .valid(r_valid)
    );
    full_adder #(.REGISTERED(1'b0)) u_comb (
        .clk(clk), .rst_n(rst_n), .e1(e1), .e2(e2), .cin(cin), .en(en), .chain(chain),
        .sum(c_sum), .cout(c_cout), .valid(c_valid)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic a, input logic b, input logic ci, input logic ch, input logic e);
        e1 = a; e2 = b; cin = ci; chain = ch; en = e;
    endtask

    task automatic test_reset;
        #12;
        n_cmp++; if ({r_sum, r_cout, r_valid} !== 3'b000) begin n_err++; $display("FAIL reset_init got %b want 000", {r_sum, r_cout, r_valid}); end
        drive(1, 1, 1, 0, 1);
        @(negedge clk);
        n_cmp++; if ({r_sum, r_cout, r_valid} !== 3'b000) begin n_err++; $display("FAIL reset_en_ignored got %b want 000", {r_sum, r_cout, r_valid}); end
        n_cmp++; if ({c_sum, c_cout, c_valid} !== 3'b111) begin n_err++; $display("FAIL reset_comb_unforced got %b want 111", {c_sum, c_cout, c_valid}); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({r_sum, r_cout, r_valid} !== 3'b111) begin n_err++; $display("FAIL first_capture got %b want 111", {r_sum, r_cout, r_valid}); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if ({r_sum, r_cout, r_valid} !== 3'b000) begin n_err++; $display("FAIL async_reset got %b want 000", {r_sum, r_cout, r_valid}); end
        drive(0, 0, 1, 1, 0);
        #1;
        n_cmp++; if ({c_sum, c_cout} !== 2'b00) begin n_err++; $display("FAIL reset_comb_chain got %b want 00", {c_sum, c_cout}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        logic [2:0] v [3] = '{3'b000, 3'b101, 3'b011};
        logic [1:0] w [3] = '{2'b00, 2'b01, 2'b01};
        for (int i = 0; i < 3; i++) begin
            drive(v[i][2], v[i][1], v[i][0], 0, 1);
            @(negedge clk);
            n_cmp++; if ({r_sum, r_cout, r_valid} !== {w[i], 1'b1}) begin n_err++; $display("FAIL directed_%0d got %b want %b", i, {r_sum, r_cout, r_valid}, {w[i], 1'b1}); end
        end
    endtask

    task automatic test_exhaustive;
        logic [7:0] s_tab = 8'b1001_0110, c_tab = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            drive(i[2], i[1], i[0], 0, 1);
            #1;
            n_cmp++; if ({c_sum, c_cout, c_valid} !== {s_tab[i], c_tab[i], 1'b1}) begin n_err++; $display("FAIL exh_comb_%0d got %b want %b", i, {c_sum, c_cout, c_valid}, {s_tab[i], c_tab[i], 1'b1}); end
            @(negedge clk);
            n_cmp++; if ({r_sum, r_cout, r_valid} !== {s_tab[i], c_tab[i], 1'b1}) begin n_err++; $display("FAIL exh_reg_%0d got %b want %b", i, {r_sum, r_cout, r_valid}, {s_tab[i], c_tab[i], 1'b1}); end
        end
    endtask

    task automatic test_hold;
        logic [2:0] v [3] = '{3'b111, 3'b001, 3'b100};
        logic [1:0] w [3] = '{2'b11, 2'b10, 2'b10};
        drive(1, 1, 0, 0, 1);
        @(negedge clk);
        n_cmp++; if ({r_sum, r_cout, r_valid} !== 3'b011) begin n_err++; $display("FAIL hold_capture got %b want 011", {r_sum, r_cout, r_valid}); end
        for (int i = 0; i < 3; i++) begin
            drive(v[i][2], v[i][1], v[i][0], 0, 0);
            #1;
            n_cmp++; if ({c_sum, c_cout, c_valid} !== {w[i], 1'b0}) begin n_err++; $display("FAIL hold_comb_%0d got %b want %b", i, {c_sum, c_cout, c_valid}, {w[i], 1'b0}); end
            @(negedge clk);
            n_cmp++; if ({r_sum, r_cout, r_valid} !== 3'b010) begin n_err++; $display("FAIL hold_reg_%0d got %b want 010", i, {r_sum, r_cout, r_valid}); end
        end
    endtask

    task automatic test_serial;
        logic [3:0] a = 4'b1011, b = 4'b0110, s = 4'b0001;
        logic [3:0] c = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            drive(a[i], b[i], 1'b0, i != 0, 1);
            #1;
            n_cmp++; if ({c_sum, c_cout} !== {s[i], c[i]}) begin n_err++; $display("FAIL serial_comb_%0d got %b want %b", i, {c_sum, c_cout}, {s[i], c[i]}); end
            @(negedge clk);
            n_cmp++; if ({r_sum, r_cout, r_valid} !== {s[i], c[i], 1'b1}) begin n_err++; $display("FAIL serial_reg_%0d got %b want %b", i, {r_sum, r_cout, r_valid}, {s[i], c[i], 1'b1}); end
        end
    endtask

    task automatic test_unused_carry;
        drive(1, 1, 0, 0, 1);
        @(negedge clk);
        drive(1, 0, 0, 1, 0);
        #1;
        n_cmp++; if ({c_sum, c_cout} !== 2'b01) begin n_err++; $display("FAIL chain1_cin0 got %b want 01", {c_sum, c_cout}); end
        cin = 1'b1;
        #1;
        n_cmp++; if ({c_sum, c_cout} !== 2'b01) begin n_err++; $display("FAIL chain1_cin1 got %b want 01", {c_sum, c_cout}); end
        chain = 1'b0; cin = 1'b0;
        #1;
        n_cmp++; if ({c_sum, c_cout} !== 2'b10) begin n_err++; $display("FAIL chain0_ignores_carry got %b want 10", {c_sum, c_cout}); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_serial;
        drive(1, 1, 0, 0, 1);
        @(negedge clk);
        n_cmp++; if ({r_sum, r_cout} !== 2'b01) begin n_err++; $display("FAIL mid_pre got %b want 01", {r_sum, r_cout}); end
        en = 1'b0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        drive(0, 0, 1, 1, 1);
        #1;
        n_cmp++; if ({c_sum, c_cout} !== 2'b00) begin n_err++; $display("FAIL mid_comb got %b want 00", {c_sum, c_cout}); end
        @(negedge clk);
        n_cmp++; if ({r_sum, r_cout, r_valid} !== 3'b001) begin n_err++; $display("FAIL mid_reg got %b want 001", {r_sum, r_cout, r_valid}); end
        drive(0, 0, 0, 0, 0);
        @(negedge clk);
        n_cmp++; if (r_valid !== 1'b0) begin n_err++; $display("FAIL valid_drop got %b want 0", r_valid); end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_exhaustive;
        test_hold;
        test_serial;
        test_unused_carry;
        test_reset_mid_serial;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
